// File: rtl/pulse_gated_fifo_if.sv
// Valid/ready stream bundle used on both sides of pulse_gated_fifo.
// master drives valid/data, slave drives ready.
interface pulse_gated_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pulse_gated_fifo.sv
// Rate-adapting FIFO: full-rate push side, output register that only moves on pulse cycles.
// Optional `level` port enabled by defining PULSE_GATED_FIFO_LEVEL_EN.
module pulse_gated_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pulse,
  pulse_gated_fifo_if.slave             producer,
  pulse_gated_fifo_if.master            consumer
`ifdef PULSE_GATED_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+2)-1:0]    level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             out_valid, out_valid_nxt;
  logic [WIDTH-1:0] out_data, out_data_nxt;
  logic             push, pop, load, refill;

  // Ready depends only on registered count, never on same-cycle pops.
  assign producer.ready = !reset && (count < CW'(DEPTH));
  assign consumer.valid = out_valid;
  assign consumer.data  = out_data;

  always_comb begin
    push          = producer.valid && producer.ready;
    pop           = pulse && out_valid && consumer.ready;
    refill        = pulse && (!out_valid || pop);
    // count is the registered value, so this cycle's write is not yet eligible
    load          = refill && (count != '0);
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    if (push) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
    end
    if (refill) begin
      out_valid_nxt = load;
    end
    if (load) begin
      rd_ptr_nxt   = rd_ptr + AW'(1);
      out_data_nxt = mem[rd_ptr];
    end
    count_nxt = count + CW'(push) - CW'(load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Storage array needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= producer.data;
    end
  end

`ifdef PULSE_GATED_FIFO_LEVEL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= LW'(count_nxt) + LW'(out_valid_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_pulse_gated_fifo.sv
// Directed self-checking bench for pulse_gated_fifo (DEPTH=4, WIDTH=32).
// Level checks run only when PULSE_GATED_FIFO_LEVEL_EN is defined.
module tb_pulse_gated_fifo;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic pulse;
  int   checks = 0;
  int   errors = 0;

  pulse_gated_fifo_if #(.WIDTH(WIDTH)) producer ();
  pulse_gated_fifo_if #(.WIDTH(WIDTH)) consumer ();
`ifdef PULSE_GATED_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  pulse_gated_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse    (pulse),
    .producer (producer),
    .consumer (consumer)
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    pulse          = 1'b0;
    producer.valid = 1'b0;
    producer.data  = '0;
    consumer.ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int idle_bad;
    reset = 1'b1; pulse = 1'b0; producer.valid = 1'b0; producer.data = '0; consumer.ready = 1'b0;
    #1;
    checks++;
    if (producer.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", producer.ready); end
    tick(); tick();
    checks++;
    if (consumer.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", consumer.valid); end
    checks++;
    if (consumer.data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", consumer.data); end
    reset = 1'b0;
    #1;
    checks++;
    if (producer.ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", producer.ready); end
    idle_bad = 0;
    for (int c = 0; c < 12; c++) begin
      pulse = (c % 4 == 0);
      tick();
      if (consumer.valid !== 1'b0 || consumer.data !== 32'h0) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_output got %0d bad cycles want 0", idle_bad); end
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL idle_level got %0d want 0", level); end
`endif
  endtask

  task automatic test_latency();
    logic        exp_v;
    logic [31:0] exp_d;
    do_reset();
    consumer.ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      pulse          = (c % 4 == 3);
      producer.valid = (c < 2);
      producer.data  = (c == 0) ? 32'hA1 : 32'hA2;
      #1;
      if (c < 2) begin
        checks++;
        if (producer.ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready c=%0d got %b want 1", c, producer.ready); end
      end
      exp_v = (c >= 4 && c < 12);
      exp_d = (c < 8) ? 32'hA1 : 32'hA2;
      checks++;
      if (consumer.valid !== exp_v) begin errors++; $display("FAIL lat_valid c=%0d got %b want %b", c, consumer.valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (consumer.data !== exp_d) begin errors++; $display("FAIL lat_data c=%0d got %h want %h", c, consumer.data, exp_d); end
      end
      tick();
    end
    producer.valid = 1'b0;
  endtask

  task automatic test_full();
    int          accepted;
    logic [31:0] d;
    do_reset();
    pulse = 1'b1; consumer.ready = 1'b0; producer.valid = 1'b1;
    d = 32'h10; accepted = 0;
    for (int c = 0; c < 10; c++) begin
      producer.data = d;
      #1;
      if (producer.ready === 1'b1) begin accepted++; d = d + 32'd1; end
      tick();
    end
    checks++;
    if (accepted != 5) begin errors++; $display("FAIL full_accepted got %0d want 5", accepted); end
    checks++;
    if (producer.ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", producer.ready); end
    checks++;
    if (consumer.valid !== 1'b1 || consumer.data !== 32'h10) begin
      errors++; $display("FAIL full_head got %b/%h want 1/00000010", consumer.valid, consumer.data);
    end
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd5) begin errors++; $display("FAIL full_level got %0d want 5", level); end
`endif
  endtask

  task automatic test_pop_full();
    // Continues from the full state left by test_full, 0x15 waiting at the input.
    consumer.ready = 1'b1; pulse = 1'b1;
    tick();
    consumer.ready = 1'b0; pulse = 1'b0;
    checks++;
    if (consumer.data !== 32'h11) begin errors++; $display("FAIL popfull_data got %h want 00000011", consumer.data); end
    checks++;
    if (producer.ready !== 1'b1) begin errors++; $display("FAIL popfull_in_ready got %b want 1", producer.ready); end
    tick();
    producer.valid = 1'b0;
    checks++;
    if (producer.ready !== 1'b0) begin errors++; $display("FAIL refill_in_ready got %b want 0", producer.ready); end
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd5) begin errors++; $display("FAIL refill_level got %0d want 5", level); end
`endif
    pulse = 1'b1; consumer.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (consumer.valid !== 1'b1 || consumer.data !== 32'h11 + 32'(i)) begin
        errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, consumer.valid, consumer.data, 32'h11 + 32'(i));
      end
      tick();
    end
    checks++;
    if (consumer.valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", consumer.valid); end
  endtask

  task automatic test_nonpulse_ready();
    int bad;
    do_reset();
    pulse = 1'b1; consumer.ready = 1'b0;
    producer.valid = 1'b1; producer.data = 32'h21; tick();
    producer.data = 32'h22; tick();
    producer.valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      pulse          = (c % 4 == 0);
      consumer.ready = !pulse;
      #1;
      if (consumer.valid !== 1'b1 || consumer.data !== 32'h21) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || consumer.data !== 32'h21) begin
      errors++; $display("FAIL nonpulse_hold got %0d bad cycles data %h want 0/00000021", bad, consumer.data);
    end
    pulse = 1'b1; consumer.ready = 1'b1;
    tick();
    checks++;
    if (consumer.valid !== 1'b1 || consumer.data !== 32'h22) begin
      errors++; $display("FAIL nonpulse_next got %b/%h want 1/00000022", consumer.valid, consumer.data);
    end
    consumer.ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse = 1'b1; consumer.ready = 1'b0; producer.valid = 1'b1;
    producer.data = 32'h31; tick();
    producer.data = 32'h32; tick();
    producer.data = 32'h33; tick();
    producer.valid = 1'b0;
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d want 3", level); end
`endif
    reset = 1'b1;
    #1;
    checks++;
    if (producer.ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", producer.ready); end
    tick();
    reset = 1'b0;
    checks++;
    if (consumer.valid !== 1'b0 || consumer.data !== 32'h0) begin
      errors++; $display("FAIL mid_out got %b/%h want 0/00000000", consumer.valid, consumer.data);
    end
`ifdef PULSE_GATED_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
`endif
    consumer.ready = 1'b1;
    producer.valid = 1'b1; producer.data = 32'h55; tick();
    producer.valid = 1'b0; tick();
    checks++;
    if (consumer.valid !== 1'b1 || consumer.data !== 32'h55) begin
      errors++; $display("FAIL mid_first got %b/%h want 1/00000055", consumer.valid, consumer.data);
    end
    tick();
    checks++;
    if (consumer.valid !== 1'b0) begin errors++; $display("FAIL mid_empty got %b want 0", consumer.valid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_pop_full();
    test_nonpulse_ready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gated_fifo.md
# pulse_gated_fifo

Rate-adapting FIFO that accepts a full-rate valid/ready stream on `clk` and presents it to a consumer that only acts on strobe cycles marked by a periodic `pulse` input (typically a `pulse_generator` output with BEATS = N). The output side changes only at the clock edge that ends a pulse cycle, so `out_data`/`out_valid` stay stable for a whole strobe period. It sits directly downstream of the pulse generator and directly upstream of multi-cycle or clock-enabled logic such as slow bus or serializer stages.

## Interface
- `WIDTH`, 32, payload width in bits (≥ 1).
- `DEPTH`, 4, storage entries, power of two, ≥ 2; total capacity is DEPTH + 1 (storage plus output register).

- `clk`  input  1  clock; all logic on posedge.
- `reset`  input  1  reset, synchronous, active-high; clock clk.
- `pulse`  input  1  strobe; a cycle with `pulse`=1 is a consumer beat.
- `in_valid`  input  1  producer has data.
- `in_ready`  output  1  FIFO can accept; combinational from registered state only.
- `in_data`  input  WIDTH  producer payload.
- `out_valid`  output  1  registered; `out_data` holds a valid entry.
- `out_ready`  input  1  consumer accepts; sampled only on pulse cycles.
- `out_data`  output  WIDTH  registered payload.
- `level`  output  $clog2(DEPTH+2)  entries held (only with `PULSE_GATED_FIFO_LEVEL_EN`).

## Operation
- Push: `in_valid && in_ready` writes `in_data` into storage at the write pointer. `in_ready` = !reset && (storage count < DEPTH).
- Pop: only on a pulse cycle with `out_valid && out_ready`. `out_ready` on non-pulse cycles is ignored.
- Output register load, pulse cycles only. If the output is empty or popped this cycle, load the oldest storage entry, or go empty if storage holds none. Otherwise hold.
- Storage entries written in the current cycle are not eligible for the output load in that same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Storage count is log2(DEPTH)+1 bits. Push and load in the same cycle leave the count unchanged.
- Full: push is refused (`in_ready`=0) and data is not dropped. A pop on a full FIFO frees a slot, and `in_ready` rises the following cycle.
- `pulse` held at 1 permanently gives a plain FIFO with a registered output and one-beat throughput.
- Order is strictly preserved. There is no bypass path from input to output.

## Timing
- Reset (also mid-operation): pointers, count and `level` are cleared to 0, `out_valid`=0 and `out_data`=0 at the next edge. All contents are discarded. `in_ready`=0 while `reset` is high and 1 in the first cycle after.
- Latency: an entry written at cycle t into an otherwise empty FIFO is visible from the edge ending the first pulse cycle p > t, i.e. at cycle p+1. This gives a minimum of 2 cycles when `pulse` is always 1.
- `out_valid`/`out_data` change only at edges ending pulse cycles, and are constant between them.
- Throughput: at most one pop per pulse and one push per clock.

## Configuration
- `PULSE_GATED_FIFO_LEVEL_EN` defined: the `level` port exists and equals storage count + `out_valid`, registered, in the range 0..DEPTH+1.
- Not defined: the `level` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle, `pulse` every 4th cycle: `out_valid`=0, `out_data`=0, and `in_ready`=1 the cycle after reset drops.
- BEATS=4 pulse, push 0xA1 at cycle 0 and 0xA2 at cycle 1, `out_ready`=1. Required: `out_data`=0xA1 from the edge after the first pulse cycle > 0, held 4 cycles, then 0xA2 for 4 cycles, then `out_valid`=0.
- DEPTH=4, `out_ready`=0, push 0x10..0x16 with `pulse` active. Required: 5 accepted (0x10..0x14), `in_ready`=0 after that, `level`=5, and 0x15 is held at the input with `in_valid` still high.
- Full FIFO, then one pulse with `out_ready`=1: pops 0x10, `out_data`=0x11, and `in_ready`=1 the next cycle, after which 0x15 is accepted.
- `out_ready` asserted only on non-pulse cycles for 20 cycles: no pop occurs and `out_data` stays unchanged.
- Reset asserted with 3 entries held: the next edge gives `out_valid`=0 and `level`=0. A subsequent push of 0x55 is the first entry output.
